// File: rtl/ysyx_22051013_axi_rd_arbiter_pkg.sv
// Shared AXI read-arbiter definitions: bus widths, FSM state encodings and grant indices.
// Every arbiter file imports this package, so none of these values is defined anywhere else.
package ysyx_22051013_axi_rd_arbiter_pkg;

  localparam int ADDR = 64;
  localparam int DATA = 64;
  localparam int RESP = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_e;

  // Grant index doubles as the round-robin history bit.
  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

endpackage

// File: rtl/ysyx_22051013_axi_rd_arbiter_rr_arb2.sv
// Two-requester winner select: a lone requester always wins; on a tie the winner is
// either the master not granted last (RR_EN=1) or always the LSU (RR_EN=0).
module ysyx_22051013_rr_arb2
  import ysyx_22051013_axi_rd_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic req_ifu,
  input  logic req_lsu,
  input  logic last_grant,
  output logic grant,
  output logic grant_valid
);

  always_comb begin
    grant_valid = req_ifu | req_lsu;
    grant       = GNT_IFU;
    if (req_ifu && req_lsu) begin
      grant = (RR_EN != 0) ? ~last_grant : GNT_LSU;
    end else if (req_lsu) begin
      grant = GNT_LSU;
    end
  end

endmodule

// File: rtl/ysyx_22051013_axi_rd_arbiter.sv
// Arbitrates the IFU and LSU AXI read channels onto one memory slave.
// At most one transaction is in flight: IDLE (arbitrate) -> ADDR (slave AR) -> DATA (one R beat).
module ysyx_22051013_axi_rd_arbiter
  import ysyx_22051013_axi_rd_arbiter_pkg::*;
#(
  parameter int RR_EN = 1
) (
  input  logic            clk,
  input  logic            rst,

  input  logic [ADDR-1:0] ifu_ar_addr,
  input  logic            ifu_ar_valid,
  output logic            ifu_ar_ready,
  output logic [DATA-1:0] ifu_r_data,
  output logic [RESP-1:0] ifu_r_resp,
  output logic            ifu_r_valid,
  input  logic            ifu_r_ready,

  input  logic [ADDR-1:0] lsu_ar_addr,
  input  logic            lsu_ar_valid,
  output logic            lsu_ar_ready,
  output logic [DATA-1:0] lsu_r_data,
  output logic [RESP-1:0] lsu_r_resp,
  output logic            lsu_r_valid,
  input  logic            lsu_r_ready,

  output logic [ADDR-1:0] s_ar_addr,
  output logic            s_ar_valid,
  input  logic            s_ar_ready,
  input  logic [DATA-1:0] s_r_data,
  input  logic [RESP-1:0] s_r_resp,
  input  logic            s_r_valid,
  output logic            s_r_ready
);

  state_e          state_reg;
  state_e          state_next;
  logic [ADDR-1:0] addr_reg;
  logic            gnt_reg;
  logic            last_grant_reg;
  logic            win;
  logic            win_valid;
  logic            ar_hs;

  ysyx_22051013_rr_arb2 #(
    .RR_EN(RR_EN)
  ) u_arb (
    .req_ifu    (ifu_ar_valid),
    .req_lsu    (lsu_ar_valid),
    .last_grant (last_grant_reg),
    .grant      (win),
    .grant_valid(win_valid)
  );

  // The winner's ready is only raised while its valid is high, so any winner is a handshake.
  assign ar_hs = (state_reg == S_IDLE) && win_valid && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      addr_reg       <= '0;
      gnt_reg        <= GNT_IFU;
      last_grant_reg <= GNT_IFU;
    end else begin
      state_reg <= state_next;
      if (ar_hs) begin
        addr_reg       <= (win == GNT_LSU) ? lsu_ar_addr : ifu_ar_addr;
        gnt_reg        <= win;
        last_grant_reg <= win;
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    ifu_ar_ready = 1'b0;
    lsu_ar_ready = 1'b0;
    ifu_r_valid  = 1'b0;
    ifu_r_data   = '0;
    ifu_r_resp   = '0;
    lsu_r_valid  = 1'b0;
    lsu_r_data   = '0;
    lsu_r_resp   = '0;
    s_ar_valid   = 1'b0;
    s_ar_addr    = '0;
    s_r_ready    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (ar_hs) begin
          if (win == GNT_LSU) lsu_ar_ready = 1'b1;
          else                ifu_ar_ready = 1'b1;
          state_next = S_ADDR;
        end
      end

      S_ADDR: begin
        s_ar_valid = 1'b1;
        s_ar_addr  = addr_reg;
        if (s_ar_ready) state_next = S_DATA;
      end

      S_DATA: begin
        if (gnt_reg == GNT_LSU) begin
          lsu_r_valid = s_r_valid;
          lsu_r_data  = s_r_data;
          lsu_r_resp  = s_r_resp;
          s_r_ready   = lsu_r_ready;
          if (s_r_valid && lsu_r_ready) state_next = S_IDLE;
        end else begin
          ifu_r_valid = s_r_valid;
          ifu_r_data  = s_r_data;
          ifu_r_resp  = s_r_resp;
          s_r_ready   = ifu_r_ready;
          if (s_r_valid && ifu_r_ready) state_next = S_IDLE;
        end
      end

      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_22051013_axi_rd_arbiter.sv
// Bench for the read arbiter: instance 0 is round-robin, instance 1 fixed LSU priority.
// Transactions are checked against a grant model derived from the arbitration rules.
module tb_ysyx_22051013_axi_rd_arbiter;

  logic        clk;
  logic        rst;

  logic [63:0] ifu_ar_addr  [2];
  logic        ifu_ar_valid [2];
  logic        ifu_ar_ready [2];
  logic [63:0] ifu_r_data   [2];
  logic [1:0]  ifu_r_resp   [2];
  logic        ifu_r_valid  [2];
  logic        ifu_r_ready  [2];
  logic [63:0] lsu_ar_addr  [2];
  logic        lsu_ar_valid [2];
  logic        lsu_ar_ready [2];
  logic [63:0] lsu_r_data   [2];
  logic [1:0]  lsu_r_resp   [2];
  logic        lsu_r_valid  [2];
  logic        lsu_r_ready  [2];
  logic [63:0] s_ar_addr    [2];
  logic        s_ar_valid   [2];
  logic        s_ar_ready   [2];
  logic [63:0] s_r_data     [2];
  logic [1:0]  s_r_resp     [2];
  logic        s_r_valid    [2];
  logic        s_r_ready    [2];

  int vectors     = 0;
  int miscompares = 0;
  bit model_last [2];   // 0 = IFU granted last, 1 = LSU granted last

  ysyx_22051013_axi_rd_arbiter #(.RR_EN(1)) dut_rr (
    .clk(clk), .rst(rst),
    .ifu_ar_addr(ifu_ar_addr[0]), .ifu_ar_valid(ifu_ar_valid[0]), .ifu_ar_ready(ifu_ar_ready[0]),
    .ifu_r_data(ifu_r_data[0]), .ifu_r_resp(ifu_r_resp[0]), .ifu_r_valid(ifu_r_valid[0]), .ifu_r_ready(ifu_r_ready[0]),
    .lsu_ar_addr(lsu_ar_addr[0]), .lsu_ar_valid(lsu_ar_valid[0]), .lsu_ar_ready(lsu_ar_ready[0]),
    .lsu_r_data(lsu_r_data[0]), .lsu_r_resp(lsu_r_resp[0]), .lsu_r_valid(lsu_r_valid[0]), .lsu_r_ready(lsu_r_ready[0]),
    .s_ar_addr(s_ar_addr[0]), .s_ar_valid(s_ar_valid[0]), .s_ar_ready(s_ar_ready[0]),
    .s_r_data(s_r_data[0]), .s_r_resp(s_r_resp[0]), .s_r_valid(s_r_valid[0]), .s_r_ready(s_r_ready[0])
  );

  ysyx_22051013_axi_rd_arbiter #(.RR_EN(0)) dut_fp (
    .clk(clk), .rst(rst),
    .ifu_ar_addr(ifu_ar_addr[1]), .ifu_ar_valid(ifu_ar_valid[1]), .ifu_ar_ready(ifu_ar_ready[1]),
    .ifu_r_data(ifu_r_data[1]), .ifu_r_resp(ifu_r_resp[1]), .ifu_r_valid(ifu_r_valid[1]), .ifu_r_ready(ifu_r_ready[1]),
    .lsu_ar_addr(lsu_ar_addr[1]), .lsu_ar_valid(lsu_ar_valid[1]), .lsu_ar_ready(lsu_ar_ready[1]),
    .lsu_r_data(lsu_r_data[1]), .lsu_r_resp(lsu_r_resp[1]), .lsu_r_valid(lsu_r_valid[1]), .lsu_r_ready(lsu_r_ready[1]),
    .s_ar_addr(s_ar_addr[1]), .s_ar_valid(s_ar_valid[1]), .s_ar_ready(s_ar_ready[1]),
    .s_r_data(s_r_data[1]), .s_r_resp(s_r_resp[1]), .s_r_valid(s_r_valid[1]), .s_r_ready(s_r_ready[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs(input int u);
    ifu_ar_addr[u] = '0; ifu_ar_valid[u] = 1'b0; ifu_r_ready[u] = 1'b0;
    lsu_ar_addr[u] = '0; lsu_ar_valid[u] = 1'b0; lsu_r_ready[u] = 1'b0;
    s_ar_ready[u]  = 1'b0; s_r_data[u] = '0; s_r_resp[u] = '0; s_r_valid[u] = 1'b0;
  endtask

  // Reference arbitration: lone requester wins; tie goes to the other master (RR) or LSU (fixed).
  function automatic int pick(input int u, input bit ri, input bit rl);
    if (ri && !rl) return 0;
    if (rl && !ri) return 1;
    if (u == 0) return model_last[0] ? 0 : 1;
    return 1;
  endfunction

  // One complete read on instance u; entered and left with the DUT idle.
  task automatic run_txn(input int u, input bit ri, input bit rl, input logic [63:0] a_i,
                         input logic [63:0] a_l, input logic [63:0] d, input logic [1:0] resp,
                         input int ar_dly, input int r_dly, output int g);
    int w;
    logic [63:0] a_w;
    logic gv, ov;
    logic [63:0] gd, od;
    logic [1:0] gr, orr;
    w   = pick(u, ri, rl);
    g   = w;
    a_w = (w == 1) ? a_l : a_i;
    ifu_ar_addr[u] = a_i; lsu_ar_addr[u] = a_l;
    ifu_ar_valid[u] = ri; lsu_ar_valid[u] = rl;
    #1;
    vectors++;
    if ({ifu_ar_ready[u], lsu_ar_ready[u], s_ar_valid[u]} !== {w == 0, w == 1, 1'b0})
      $display("FAIL ar_grant u=%0d got ifu/lsu/s_ar_valid=%b%b%b want %b%b0", u,
               ifu_ar_ready[u], lsu_ar_ready[u], s_ar_valid[u], w == 0, w == 1);
    if ({ifu_ar_ready[u], lsu_ar_ready[u], s_ar_valid[u]} !== {w == 0, w == 1, 1'b0}) miscompares++;
    step();
    ifu_ar_valid[u] = 1'b0; lsu_ar_valid[u] = 1'b0;
    model_last[u] = (w == 1);

    for (int k = 0; k <= ar_dly; k++) begin
      s_ar_ready[u] = (k == ar_dly);
      s_r_valid[u]  = (k == 0);        // stray beat during ADDR must be ignored
      s_r_data[u]   = ~d;
      #1;
      vectors++;
      if ({s_ar_valid[u], s_ar_addr[u]} !== {1'b1, a_w}) begin
        miscompares++;
        $display("FAIL s_ar u=%0d k=%0d got valid=%b addr=%h want valid=1 addr=%h", u, k,
                 s_ar_valid[u], s_ar_addr[u], a_w);
      end
      vectors++;
      if ({ifu_ar_ready[u], lsu_ar_ready[u], s_r_ready[u], ifu_r_valid[u], lsu_r_valid[u]} !== 5'b0) begin
        miscompares++;
        $display("FAIL addr_quiet u=%0d k=%0d got ar_rdy=%b%b s_r_ready=%b r_valid=%b%b want 0", u, k,
                 ifu_ar_ready[u], lsu_ar_ready[u], s_r_ready[u], ifu_r_valid[u], lsu_r_valid[u]);
      end
      step();
    end
    s_ar_ready[u] = 1'b0;

    s_r_valid[u] = 1'b1; s_r_data[u] = d; s_r_resp[u] = resp;
    for (int k = 0; k <= r_dly; k++) begin
      if (w == 1) begin lsu_r_ready[u] = (k == r_dly); ifu_r_ready[u] = 1'b1; end
      else        begin ifu_r_ready[u] = (k == r_dly); lsu_r_ready[u] = 1'b1; end
      #1;
      gv = (w == 1) ? lsu_r_valid[u] : ifu_r_valid[u];
      gd = (w == 1) ? lsu_r_data[u]  : ifu_r_data[u];
      gr = (w == 1) ? lsu_r_resp[u]  : ifu_r_resp[u];
      ov = (w == 1) ? ifu_r_valid[u] : lsu_r_valid[u];
      od = (w == 1) ? ifu_r_data[u]  : lsu_r_data[u];
      orr = (w == 1) ? ifu_r_resp[u] : lsu_r_resp[u];
      vectors++;
      if ({gv, gd, gr} !== {1'b1, d, resp}) begin
        miscompares++;
        $display("FAIL r_granted u=%0d k=%0d got v=%b d=%h r=%b want v=1 d=%h r=%b", u, k, gv, gd, gr, d, resp);
      end
      vectors++;
      if ({ov, od, orr} !== '0) begin
        miscompares++;
        $display("FAIL r_other u=%0d k=%0d got v=%b d=%h r=%b want 0", u, k, ov, od, orr);
      end
      vectors++;
      if ({s_r_ready[u], s_ar_valid[u]} !== {k == r_dly, 1'b0}) begin
        miscompares++;
        $display("FAIL s_r_ready u=%0d k=%0d got %b s_ar_valid=%b want %b/0", u, k,
                 s_r_ready[u], s_ar_valid[u], k == r_dly);
      end
      step();
    end
    idle_inputs(u);

    s_r_valid[u] = 1'b1;  // stray beat in IDLE must be ignored
    ifu_r_ready[u] = 1'b1; lsu_r_ready[u] = 1'b1;
    #1;
    vectors++;
    if ({s_r_ready[u], ifu_r_valid[u], lsu_r_valid[u], s_ar_valid[u]} !== 4'b0) begin
      miscompares++;
      $display("FAIL back_idle u=%0d got s_r_ready=%b r_valid=%b%b s_ar_valid=%b want 0", u,
               s_r_ready[u], ifu_r_valid[u], lsu_r_valid[u], s_ar_valid[u]);
    end
    idle_inputs(u);
    $display("txn u=%0d req=%b%b grant=%s addr=%h data=%h resp=%b ar_dly=%0d r_dly=%0d", u, rl, ri,
             (w == 1) ? "LSU" : "IFU", a_w, d, resp, ar_dly, r_dly);
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      idle_inputs(u);
      ifu_ar_valid[u] = 1'b1; lsu_ar_valid[u] = 1'b1; s_r_valid[u] = 1'b1;
      ifu_r_ready[u] = 1'b1; lsu_r_ready[u] = 1'b1; s_ar_ready[u] = 1'b1;
      s_r_data[u] = 64'hdead_beef; s_r_resp[u] = 2'b11;
    end
    step();
    for (int u = 0; u < 2; u++) begin
      vectors++;
      if ({ifu_ar_ready[u], lsu_ar_ready[u], s_ar_valid[u], s_r_ready[u], ifu_r_valid[u], lsu_r_valid[u]} !== 6'b0) begin
        miscompares++;
        $display("FAIL reset_hs u=%0d got %b%b%b%b%b%b want 000000", u, ifu_ar_ready[u], lsu_ar_ready[u],
                 s_ar_valid[u], s_r_ready[u], ifu_r_valid[u], lsu_r_valid[u]);
      end
      vectors++;
      if ({s_ar_addr[u], ifu_r_data[u], lsu_r_data[u], ifu_r_resp[u], lsu_r_resp[u]} !== '0) begin
        miscompares++;
        $display("FAIL reset_data u=%0d got addr=%h ifu_d=%h lsu_d=%h resp=%b%b want 0", u, s_ar_addr[u],
                 ifu_r_data[u], lsu_r_data[u], ifu_r_resp[u], lsu_r_resp[u]);
      end
      idle_inputs(u);
      model_last[u] = 1'b0;
    end
    #2 rst = 1'b0;
    step();
  endtask

  task automatic test_single_ifu();
    int g;
    run_txn(0, 1'b1, 1'b0, 64'h8000_0000, 64'h0, 64'h1234, 2'b00, 0, 0, g);
  endtask

  task automatic test_rr_alternate();
    int g;
    int exp_seq [4] = '{1, 0, 1, 0};
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 1'b1, 1'b1, 64'h8000_1000 + 64'(i), 64'h8000_2000 + 64'(i), 64'(i), 2'b00, 0, 0, g);
      vectors++;
      if (g !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL rr_seq i=%0d got grant=%0d want %0d", i, g, exp_seq[i]);
      end
    end
  endtask

  task automatic test_fixed_prio();
    int g;
    for (int i = 0; i < 3; i++)
      run_txn(1, 1'b1, 1'b1, 64'h100 + 64'(i), 64'h200 + 64'(i), 64'h55 + 64'(i), 2'b00, 0, 0, g);
    run_txn(1, 1'b1, 1'b0, 64'h300, 64'h0, 64'h66, 2'b00, 0, 0, g);
  endtask

  task automatic test_backpressure();
    int g;
    run_txn(0, 1'b1, 1'b0, 64'h8000_0040, 64'h0, 64'hcafe_f00d, 2'b00, 3, 2, g);
  endtask

  task automatic test_resp_error();
    int g;
    run_txn(0, 1'b0, 1'b1, 64'h0, 64'h8000_0080, 64'hbad0, 2'b10, 1, 1, g);
  endtask

  task automatic test_drop();
    int g;
    ifu_ar_valid[0] = 1'b1;
    #1;
    vectors++;
    if ({ifu_ar_ready[0], lsu_ar_ready[0]} !== 2'b10) begin
      miscompares++;
      $display("FAIL drop_pre got ifu/lsu ready=%b%b want 10", ifu_ar_ready[0], lsu_ar_ready[0]);
    end
    ifu_ar_valid[0] = 1'b0;
    #1;
    vectors++;
    if (ifu_ar_ready[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_ready got %b want 0", ifu_ar_ready[0]);
    end
    step();
    vectors++;
    if (s_ar_valid[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_idle got s_ar_valid=%b want 0", s_ar_valid[0]);
    end
    run_txn(0, 1'b1, 1'b1, 64'h10, 64'h20, 64'h30, 2'b01, 0, 0, g);
  endtask

  task automatic test_reset_mid();
    int g;
    ifu_ar_addr[0] = 64'h8000_0100; ifu_ar_valid[0] = 1'b1;
    step();
    ifu_ar_valid[0] = 1'b0; s_ar_ready[0] = 1'b1;
    step();
    s_ar_ready[0] = 1'b0; s_r_valid[0] = 1'b1; s_r_data[0] = 64'h7777; s_r_resp[0] = 2'b01;
    #1;
    vectors++;
    if ({ifu_r_valid[0], ifu_r_data[0]} !== {1'b1, 64'h7777}) begin
      miscompares++;
      $display("FAIL mid_pre got v=%b d=%h want v=1 d=7777", ifu_r_valid[0], ifu_r_data[0]);
    end
    ifu_ar_valid[0] = 1'b1; lsu_ar_valid[0] = 1'b1; ifu_r_ready[0] = 1'b1;
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({ifu_r_valid[0], ifu_r_data[0], ifu_r_resp[0], s_r_ready[0], s_ar_valid[0], s_ar_addr[0],
         ifu_ar_ready[0], lsu_ar_ready[0]} !== '0) begin
      miscompares++;
      $display("FAIL mid_rst got r_v=%b d=%h resp=%b s_r_rdy=%b s_ar_v=%b addr=%h ar_rdy=%b%b want 0",
               ifu_r_valid[0], ifu_r_data[0], ifu_r_resp[0], s_r_ready[0], s_ar_valid[0], s_ar_addr[0],
               ifu_ar_ready[0], lsu_ar_ready[0]);
    end
    idle_inputs(0);
    model_last[0] = 1'b0; model_last[1] = 1'b0;
    step();
    rst = 1'b0;
    step();
    run_txn(0, 1'b0, 1'b1, 64'h0, 64'h8000_0008, 64'h600d, 2'b00, 0, 0, g);
  endtask

  task automatic test_random();
    int g;
    int r;
    for (int i = 0; i < 60; i++) begin
      int u = i % 2;
      r = $urandom_range(1, 3);
      run_txn(u, r[0], r[1], {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3), g);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs(0);
    idle_inputs(1);
    test_reset();
    test_single_ifu();
    test_rr_alternate();
    test_fixed_prio();
    test_backpressure();
    test_resp_error();
    test_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ysyx_22051013_axi_rd_arbiter.md
YSYX_22051013_AXI_RD_ARBITER -- requirements
Module: ysyx_22051013_axi_rd_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin on simultaneous requests, 0 = fixed LSU priority.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports ifu_ar_addr / ifu_ar_valid / ifu_ar_ready  in/in/out  64/1/1  IFU (master 0) read-address channel.
REQ-005 SHALL have ports ifu_r_data / ifu_r_resp / ifu_r_valid / ifu_r_ready  out/out/out/in  64/2/1/1  IFU read-data channel.
REQ-006 SHALL have ports lsu_ar_addr / lsu_ar_valid / lsu_ar_ready  in/in/out  64/1/1  LSU (master 1) read-address channel.
REQ-007 SHALL have ports lsu_r_data / lsu_r_resp / lsu_r_valid / lsu_r_ready  out/out/out/in  64/2/1/1  LSU read-data channel.
REQ-008 SHALL have ports s_ar_addr / s_ar_valid / s_ar_ready  out/out/in  64/1/1  shared memory-slave read-address channel.
REQ-009 SHALL have ports s_r_data / s_r_resp / s_r_valid / s_r_ready  in/in/in/out  64/2/1/1  shared memory-slave read-data channel.

Function
REQ-010 SHALL implement the FSM states IDLE, ADDR and DATA, with at most one transaction outstanding.
REQ-011 In IDLE, SHALL assert ar_ready only to the arbitration winner, and only while that master's ar_valid is high; all other ar_ready SHALL be 0.
REQ-012 SHALL select the winner as follows:
- One requester: that requester wins.
- Both, RR_EN=1: the master not granted last wins.
- Both, RR_EN=0: LSU wins.
REQ-013 On the master AR handshake, SHALL latch the address and grant index, update last_grant, and go IDLE->ADDR.
REQ-014 In ADDR, SHALL drive s_ar_valid=1 and s_ar_addr=latched address, both held stable until s_ar_ready; on the handshake SHALL go ADDR->DATA.
REQ-015 s_ar_valid SHALL first assert in the cycle after the master AR handshake (latency 1 cycle), and SHALL never depend combinationally on s_ar_ready.
REQ-016 In DATA, SHALL route the read-data channel to the granted master only:
- granted r_valid = s_r_valid;
- granted r_data = s_r_data, granted r_resp = s_r_resp;
- s_r_ready = granted master's r_ready.
REQ-017 Non-granted r_valid SHALL be 0 and its r_data/r_resp SHALL be 0.
REQ-018 On the R handshake, SHALL go DATA->IDLE; a new grant SHALL be possible no earlier than the following cycle.
REQ-019 SHALL forward resp values, including non-zero (error) values, unmodified.
REQ-020 A master dropping ar_valid before its handshake SHALL lose no state; arbitration SHALL be re-evaluated every IDLE cycle.
REQ-021 An unencoded state SHALL recover to IDLE on the next clock edge.
REQ-022 A slave R beat arriving in IDLE or ADDR SHALL be ignored: s_r_ready=0, and no master r_valid.

Reset
REQ-023 While rst=1, SHALL force state=IDLE, last_grant=IFU, and latched address and grant index to 0.
REQ-024 While rst=1, SHALL drive every ready/valid output, s_ar_addr, and all r_data/r_resp outputs to 0.
REQ-025 Assertion of rst mid-transaction (ADDR or DATA) SHALL abandon the transaction immediately, without waiting for the clock.
REQ-026 After rst deasserts, the first grant SHALL follow REQ-012 with last_grant=IFU.

Structure
REQ-027 SHALL take the width macros ADDR (64), DATA (64) and RESP (2), and the state encodings S_IDLE/S_ADDR/S_DATA, from the shared AXI define file; no local redefinition.
REQ-028 SHALL place the grant-index encoding (IFU=0, LSU=1) in that same shared define file.
REQ-029 SHALL be a single module with no sub-modules; the winner-select logic may optionally be split into ysyx_22051013_rr_arb2.

Verification
REQ-030 Single IFU read: IFU ar_addr=0x8000_0000 at cycle 0 -> ifu_ar_ready=1 at cycle 0; s_ar_valid=1 with addr 0x8000_0000 at cycle 1; s_r_data 0x1234 appears on ifu_r_data; lsu_r_valid stays 0.
REQ-031 Simultaneous requests, RR_EN=1, repeated 4 times -> grants alternate LSU, IFU, LSU, IFU (first LSU, since last_grant=IFU).
REQ-032 Simultaneous requests, RR_EN=0 -> LSU granted every time while lsu_ar_valid is held; IFU is granted in the first IDLE cycle in which LSU is idle.
REQ-033 Backpressure: s_ar_ready held low 3 cycles, then ifu_r_ready held low 2 cycles -> s_ar_addr stable throughout; one R transfer only; return to IDLE.
REQ-034 rst asserted between clock edges while in DATA -> all outputs 0 immediately; a subsequent LSU read of 0x8000_0008 completes normally with resp 2'b00.
REQ-035 Slave returns s_r_resp=2'b10 -> lsu_r_resp=2'b10 on the granted channel; the arbiter returns to IDLE.
